// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file with optional write-to-read bypass and
// per-register saturating read/write access counters for the debug unit.

module ibex_register_file_mp_cnt #(
    parameter int CountWidth = 16,
    parameter int IncWidth   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic [IncWidth-1:0]   inc_i,
    output logic [CountWidth-1:0] cnt_d_o
);
    logic [CountWidth-1:0] cnt_q;
    logic [CountWidth:0]   sum;

    // inc_i never exceeds 4, so one extra bit is enough to detect overflow
    assign sum = {1'b0, cnt_q} + (CountWidth + 1)'(inc_i);

    always_comb begin
        cnt_d_o = sum[CountWidth-1:0];
        if (clr_i) begin
            cnt_d_o = '0;
        end else if (sum[CountWidth]) begin
            cnt_d_o = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d_o;
        end
    end
endmodule

module ibex_register_file_mp #(
    parameter bit RV32E         = 1'b0,
    parameter int DataWidth     = 32,
    parameter int NumReadPorts  = 2,
    parameter int NumWritePorts = 2,
    parameter bit WriteBypass   = 1'b0,
    parameter int CountWidth    = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NumReadPorts-1:0]                  re_i,
    input  logic [NumReadPorts-1:0][4:0]             raddr_i,
    output logic [NumReadPorts-1:0][DataWidth-1:0]   rdata_o,
    input  logic [NumWritePorts-1:0]                 we_i,
    input  logic [NumWritePorts-1:0][4:0]            waddr_i,
    input  logic [NumWritePorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic                                     cnt_clr_i,
    input  logic [4:0]                               cnt_addr_i,
    output logic [CountWidth-1:0]                    cnt_rd_o,
    output logic [CountWidth-1:0]                    cnt_wr_o,
    output logic                                     cnt_sat_o
);
    localparam int NumWords = RV32E ? 16 : 32;
    localparam int IncWidth = 3;

    // R0 has no storage; addresses >= NumWords never match a word and fall out as 0
    logic [NumWords-1:1][DataWidth-1:0] rf_q;
    logic [NumWords-1:1][DataWidth-1:0] wdat;
    logic [NumWords-1:1]                wen;

    logic [NumWords-1:0][IncWidth-1:0]   rd_inc, wr_inc;
    logic [NumWords-1:0][CountWidth-1:0] rd_cnt_d, wr_cnt_d;
    logic [CountWidth-1:0]               rd_sel, wr_sel;
    logic                                sat_hit;

    // Ascending port scan: the highest-numbered matching port wins
    always_comb begin
        wen  = '0;
        wdat = rf_q;
        for (int w = 1; w < NumWords; w++) begin
            for (int p = 0; p < NumWritePorts; p++) begin
                if (we_i[p] && waddr_i[p] == 5'(w)) begin
                    wen[w]  = 1'b1;
                    wdat[w] = wdata_i[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_q <= '0;
        end else begin
            for (int w = 1; w < NumWords; w++) begin
                if (wen[w]) begin
                    rf_q[w] <= wdat[w];
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NumReadPorts; k++) begin
            for (int w = 1; w < NumWords; w++) begin
                if (raddr_i[k] == 5'(w)) begin
                    rdata_o[k] = (WriteBypass && wen[w]) ? wdat[w] : rf_q[w];
                end
            end
        end
    end

    always_comb begin
        rd_inc = '0;
        wr_inc = '0;
        for (int w = 0; w < NumWords; w++) begin
            for (int k = 0; k < NumReadPorts; k++) begin
                if (re_i[k] && raddr_i[k] == 5'(w)) begin
                    rd_inc[w] = rd_inc[w] + IncWidth'(1);
                end
            end
            for (int p = 0; p < NumWritePorts; p++) begin
                if (we_i[p] && waddr_i[p] == 5'(w)) begin
                    wr_inc[w] = wr_inc[w] + IncWidth'(1);
                end
            end
        end
    end

    for (genvar w = 0; w < NumWords; w++) begin : g_cnt
        ibex_register_file_mp_cnt #(
            .CountWidth(CountWidth),
            .IncWidth  (IncWidth)
        ) u_rd_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (cnt_clr_i),
            .inc_i  (rd_inc[w]),
            .cnt_d_o(rd_cnt_d[w])
        );
        ibex_register_file_mp_cnt #(
            .CountWidth(CountWidth),
            .IncWidth  (IncWidth)
        ) u_wr_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (cnt_clr_i),
            .inc_i  (wr_inc[w]),
            .cnt_d_o(wr_cnt_d[w])
        );
    end

    // Readout and saturation look at post-update values so they track the same edge
    always_comb begin
        rd_sel  = '0;
        wr_sel  = '0;
        sat_hit = 1'b0;
        for (int w = 0; w < NumWords; w++) begin
            if (cnt_addr_i == 5'(w)) begin
                rd_sel = rd_cnt_d[w];
                wr_sel = wr_cnt_d[w];
            end
            if (&rd_cnt_d[w] || &wr_cnt_d[w]) begin
                sat_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_rd_o  <= '0;
            cnt_wr_o  <= '0;
            cnt_sat_o <= 1'b0;
        end else begin
            cnt_rd_o  <= rd_sel;
            cnt_wr_o  <= wr_sel;
            cnt_sat_o <= cnt_clr_i ? 1'b0 : (cnt_sat_o | sat_hit);
        end
    end
endmodule
